// File: rtl/uart_cmd_ctrl.sv
// UART peek/poke sequencer: 'W' hi lo data -> 'K', 'R' hi lo -> byte, other -> '?'.
// Bus request one cycle after last byte; response waits while uart_busy is high.
`timescale 1ns/1ps
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned ADDR_WIDTH     = 16
) (
  input  logic                  clk50MHz,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  uart_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  output logic                  ctrl_busy,
  output logic                  err_timeout,
  output logic                  rx_dropped
);
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, WDATA, BUS_WR, BUS_RD, TX_SEND, TX_WAIT_HI, TX_WAIT_LO
  } state_t;

  state_t                  state, state_nxt;
  logic                    is_wr, is_wr_nxt;
  logic [7:0]              addr_hi, addr_hi_nxt;
  logic [15:0]             cnt, cnt_nxt;
  logic [7:0]              tx_data_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [7:0]              mem_wdata_nxt;
  logic                    dropped_nxt;
  logic                    tmo_nxt;
  logic                    timeout;

  // Fires on the cycle the counter would reach the limit; beats a coincident byte.
  assign timeout = (state inside {ADDR_HI, ADDR_LO, WDATA}) &&
                   (({1'b0, cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));

  always_comb begin
    state_nxt     = state;
    is_wr_nxt     = is_wr;
    addr_hi_nxt   = addr_hi;
    cnt_nxt       = 16'd0;
    tx_data_nxt   = tx_data;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    dropped_nxt   = rx_dropped;
    tmo_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            is_wr_nxt = (rx_data == OP_WR);
            state_nxt = ADDR_HI;
          end else begin
            tx_data_nxt = RSP_BAD;
            state_nxt   = TX_SEND;
          end
        end
      end
      ADDR_HI, ADDR_LO, WDATA: begin
        if (timeout) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (rx_valid) begin
          if (state == ADDR_HI) begin
            addr_hi_nxt = rx_data;
            state_nxt   = ADDR_LO;
          end else if (state == ADDR_LO) begin
            mem_addr_nxt = ADDR_WIDTH'({addr_hi, rx_data});
            state_nxt    = is_wr ? WDATA : BUS_RD;
          end else begin
            mem_wdata_nxt = rx_data;
            state_nxt     = BUS_WR;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      BUS_WR: begin
        if (mem_ack) begin
          tx_data_nxt = RSP_OK;
          state_nxt   = TX_SEND;
        end
      end
      BUS_RD: begin
        if (mem_ack) begin
          tx_data_nxt = mem_rdata;
          state_nxt   = TX_SEND;
        end
      end
      TX_SEND:    if (!uart_busy) state_nxt = TX_WAIT_HI;
      TX_WAIT_HI: if (uart_busy)  state_nxt = TX_WAIT_LO;
      TX_WAIT_LO: if (!uart_busy) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (rx_valid && (state inside {BUS_WR, BUS_RD, TX_SEND, TX_WAIT_HI, TX_WAIT_LO}))
      dropped_nxt = 1'b1;
  end

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      is_wr       <= 1'b0;
      addr_hi     <= 8'h00;
      cnt         <= 16'd0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      ctrl_busy   <= 1'b0;
      err_timeout <= 1'b0;
      rx_dropped  <= 1'b0;
    end else begin
      state       <= state_nxt;
      is_wr       <= is_wr_nxt;
      addr_hi     <= addr_hi_nxt;
      cnt         <= cnt_nxt;
      tx_data     <= tx_data_nxt;
      tx_valid    <= (state == TX_SEND) && !uart_busy;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      mem_we      <= (state_nxt == BUS_WR);
      mem_re      <= (state_nxt == BUS_RD);
      ctrl_busy   <= (state_nxt != IDLE);
      err_timeout <= tmo_nxt;
      rx_dropped  <= dropped_nxt;
    end
  end
endmodule
